// File: rtl/tft_fill_gen.sv
// Rectangular window fill generator for an FSL-attached LCD controller.
// On a valid start it programs the LCD window (column/row start/end), the
// GRAM address and the GRAM-write index (13 setup words), then streams one
// colour word per pixel of the window.
//
// Ports:
//   FSL_Clk, FSL_Rst_n : clock (rising edge), asynchronous active-low reset
//   start              : one-cycle fill request, sampled only when idle
//   x0, x1, y0, y1     : inclusive window bounds
//   color              : RGB565 fill value
//   busy, done, err    : status; done/err are single-cycle pulses
//   FSL_M_Write        : word valid (already qualified by FSL_M_Full)
//   FSL_M_Data         : payload in [16:31], [0:15] always zero
//   FSL_M_Control      : 1 = register index word, 0 = data word
//   FSL_M_Full         : downstream FIFO full
module tft_fill_gen #(
  parameter int unsigned X_MAX = 239,
  parameter int unsigned Y_MAX = 319
) (
  input  logic        FSL_Clk,
  input  logic        FSL_Rst_n,
  input  logic        start,
  input  logic [7:0]  x0,
  input  logic [7:0]  x1,
  input  logic [8:0]  y0,
  input  logic [8:0]  y1,
  input  logic [15:0] color,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        FSL_M_Write,
  output logic [0:31] FSL_M_Data,
  output logic        FSL_M_Control,
  input  logic        FSL_M_Full
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSetup  = 2'd1;
  localparam logic [1:0] StPixels = 2'd2;

  localparam logic [7:0] XMax = 8'(X_MAX);
  localparam logic [8:0] YMax = 9'(Y_MAX);
  localparam logic [3:0] LastSetupIdx = 4'd12;

  logic [1:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [16:0] cnt_q, cnt_d;
  logic [7:0]  x0_q, x0_d, x1_q, x1_d;
  logic [8:0]  y0_q, y0_d, y1_q, y1_d;
  logic [15:0] color_q, color_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        req_ok;
  logic [16:0] win_w, win_h, win_n;
  logic [15:0] payload;

  assign req_ok = (x0 <= x1) && (y0 <= y1) && (x1 <= XMax) && (y1 <= YMax);

  // Pixel count computed from the live inputs so it can be loaded with the latches.
  assign win_w = 17'(x1) - 17'(x0) + 17'd1;
  assign win_h = 17'(y1) - 17'(y0) + 17'd1;
  assign win_n = win_w * win_h;

  assign busy        = (state_q == StSetup) || (state_q == StPixels);
  assign FSL_M_Write = busy && !FSL_M_Full;
  assign done        = done_q;
  assign err         = err_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    color_d = color_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (req_ok) begin
            x0_d    = x0;
            x1_d    = x1;
            y0_d    = y0;
            y1_d    = y1;
            color_d = color;
            idx_d   = 4'd0;
            cnt_d   = win_n;
            state_d = StSetup;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StSetup: begin
        if (FSL_M_Write) begin
          if (idx_q == LastSetupIdx) begin
            idx_d   = 4'd0;
            state_d = StPixels;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      StPixels: begin
        if (FSL_M_Write) begin
          cnt_d = cnt_q - 17'd1;
          if (cnt_q == 17'd1) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Setup words alternate index (even) / value (odd), so Control is ~idx[0].
  always_comb begin
    payload       = 16'h0000;
    FSL_M_Control = 1'b0;
    case (state_q)
      StSetup: begin
        FSL_M_Control = ~idx_q[0];
        case (idx_q)
          4'd0:    payload = 16'h0050;
          4'd1:    payload = 16'(x0_q);
          4'd2:    payload = 16'h0051;
          4'd3:    payload = 16'(x1_q);
          4'd4:    payload = 16'h0052;
          4'd5:    payload = 16'(y0_q);
          4'd6:    payload = 16'h0053;
          4'd7:    payload = 16'(y1_q);
          4'd8:    payload = 16'h0020;
          4'd9:    payload = 16'(x0_q);
          4'd10:   payload = 16'h0021;
          4'd11:   payload = 16'(y0_q);
          4'd12:   payload = 16'h0022;
          default: payload = 16'h0000;
        endcase
      end
      StPixels: payload = color_q;
      default:  payload = 16'h0000;
    endcase
  end

  assign FSL_M_Data = {16'h0000, payload};

  always_ff @(posedge FSL_Clk or negedge FSL_Rst_n) begin
    if (!FSL_Rst_n) begin
      state_q <= StIdle;
      idx_q   <= 4'd0;
      cnt_q   <= 17'd0;
      x0_q    <= 8'd0;
      x1_q    <= 8'd0;
      y0_q    <= 9'd0;
      y1_q    <= 9'd0;
      color_q <= 16'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      color_q <= color_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_tft_fill_gen.sv
// Self-checking bench for tft_fill_gen. A reference model builds the expected
// word list of a fill from the window and colour; a monitor records every
// accepted word and protocol observations, and each scenario task compares.
module tb_tft_fill_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  x0, x1;
  logic [8:0]  y0, y1;
  logic [15:0] color;
  logic        busy, done, err;
  logic        m_write;
  logic [0:31] m_data;
  logic        m_ctl;
  logic        m_full;

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected and observed word streams (control bit, 16-bit payload).
  bit          exp_ctl[$];
  logic [15:0] exp_dat[$];
  bit          got_ctl[$];
  logic [15:0] got_dat[$];

  // Monitor observations of the last collect call.
  int done_cnt, done_cyc, err_cnt, first_wr, stable_viol, wwf_viol, idle_wr, hi_viol;

  tft_fill_gen #(
    .X_MAX(239),
    .Y_MAX(319)
  ) dut (
    .FSL_Clk      (clk),
    .FSL_Rst_n    (rst_n),
    .start        (start),
    .x0           (x0),
    .x1           (x1),
    .y0           (y0),
    .y1           (y1),
    .color        (color),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .FSL_M_Write  (m_write),
    .FSL_M_Data   (m_data),
    .FSL_M_Control(m_ctl),
    .FSL_M_Full   (m_full)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  // Reference model: window programming then one colour word per pixel.
  function automatic void build_exp(input logic [7:0] a0, input logic [7:0] a1,
                                    input logic [8:0] b0, input logic [8:0] b1,
                                    input logic [15:0] c);
    logic [15:0] ridx[0:6];
    logic [15:0] rval[0:5];
    ridx = '{16'h0050, 16'h0051, 16'h0052, 16'h0053, 16'h0020, 16'h0021, 16'h0022};
    rval = '{16'(a0), 16'(a1), 16'(b0), 16'(b1), 16'(a0), 16'(b0)};
    exp_ctl.delete();
    exp_dat.delete();
    for (int i = 0; i < 7; i++) begin
      exp_ctl.push_back(1'b1);
      exp_dat.push_back(ridx[i]);
      if (i < 6) begin
        exp_ctl.push_back(1'b0);
        exp_dat.push_back(rval[i]);
      end
    end
    for (int r = int'(b0); r <= int'(b1); r++) begin
      for (int k = int'(a0); k <= int'(a1); k++) begin
        exp_ctl.push_back(1'b0);
        exp_dat.push_back(c);
      end
    end
  endfunction

  function automatic int first_diff();
    int n;
    n = (got_dat.size() < exp_dat.size()) ? got_dat.size() : exp_dat.size();
    for (int i = 0; i < n; i++) begin
      if (got_ctl[i] !== exp_ctl[i] || got_dat[i] !== exp_dat[i]) return i;
    end
    if (got_dat.size() != exp_dat.size()) return n;
    return -1;
  endfunction

  function automatic string diff_str(input int d);
    string s;
    s = $sformatf("word %0d: got %0d words, required %0d", d, got_dat.size(), exp_dat.size());
    if (d < got_dat.size()) s = {s, $sformatf(" got (%0b,%h)", got_ctl[d], got_dat[d])};
    if (d < exp_dat.size()) s = {s, $sformatf(" required (%0b,%h)", exp_ctl[d], exp_dat[d])};
    return s;
  endfunction

  // Issue a one-cycle start; returns #1 into the first cycle after the request.
  task automatic do_start(input logic [7:0] a0, input logic [7:0] a1, input logic [8:0] b0,
                          input logic [8:0] b1, input logic [15:0] c);
    @(posedge clk);
    #1;
    x0 = a0; x1 = a1; y0 = b0; y1 = b1; color = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Scramble the inputs so any late sampling of them would be visible.
    x0 = 8'($urandom); x1 = 8'($urandom); y0 = 9'($urandom); y1 = 9'($urandom);
    color = 16'($urandom);
  endtask

  // Record accepted words until done (cycle 1 = first cycle after start).
  // inj_cyc != 0 asserts start with the given window during that cycle.
  task automatic collect(input bit rand_full, input int max_cyc, input int inj_cyc,
                         input logic [7:0] ia0, input logic [7:0] ia1, input logic [8:0] ib0,
                         input logic [8:0] ib1, input logic [15:0] ic);
    bit          prev_blk;
    logic [0:31] prev_data;
    logic        prev_ctl;
    got_ctl.delete();
    got_dat.delete();
    done_cnt = 0; done_cyc = -1; err_cnt = 0; first_wr = -1;
    stable_viol = 0; wwf_viol = 0; idle_wr = 0; hi_viol = 0;
    prev_blk = 1'b0; prev_data = '0; prev_ctl = 1'b0;
    m_full = rand_full ? 1'($urandom_range(0, 1)) : 1'b0;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      @(negedge clk);
      if (prev_blk && (m_data !== prev_data || m_ctl !== prev_ctl)) stable_viol++;
      prev_blk  = busy && m_full;
      prev_data = m_data;
      prev_ctl  = m_ctl;
      if (m_write === 1'b1) begin
        if (m_full) wwf_viol++;
        if (!busy) idle_wr++;
        if (m_data[0:15] !== 16'h0000) hi_viol++;
        got_ctl.push_back(m_ctl);
        got_dat.push_back(m_data[16:31]);
        if (first_wr < 0) first_wr = cyc;
      end
      if (err) err_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        break;
      end
      @(posedge clk);
      #1;
      start = (inj_cyc != 0) && (cyc + 1 == inj_cyc);
      if (start) begin
        x0 = ia0; x1 = ia1; y0 = ib0; y1 = ib1; color = ic;
      end
      m_full = rand_full ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    @(posedge clk);
    #1;
    start  = 1'b0;
    m_full = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    m_full = 1'b1;
    x0 = 8'd1; x1 = 8'd2; y0 = 9'd1; y1 = 9'd2; color = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, err, m_write, m_ctl} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_status: got busy/done/err/wr/ctl=%b required 00000",
               {busy, done, err, m_write, m_ctl});
    end
    n_cmp++;
    if (m_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h required 00000000", m_data);
    end
    @(negedge clk);
    start = 1'b0;
    m_full = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, m_write} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_release_idle: got busy/wr=%b required 00", {busy, m_write});
    end
  endtask

  task automatic test_one_pixel();
    int d;
    build_exp(8'd5, 8'd5, 9'd7, 9'd7, 16'hF800);
    do_start(8'd5, 8'd5, 9'd7, 9'd7, 16'hF800);
    collect(1'b0, 100, 0, 8'd0, 8'd0, 9'd0, 9'd0, 16'd0);
    d = first_diff();
    n_cmp++;
    if (d >= 0) begin
      n_fail++;
      $display("FAIL onepx_seq: %s", diff_str(d));
    end
    n_cmp++;
    if (done_cyc !== 15 || first_wr !== 1) begin
      n_fail++;
      $display("FAIL onepx_timing: got done cycle %0d first write %0d required 15 and 1",
               done_cyc, first_wr);
    end
    n_cmp++;
    if (hi_viol !== 0 || idle_wr !== 0 || err_cnt !== 0) begin
      n_fail++;
      $display("FAIL onepx_protocol: got hi=%0d idle_wr=%0d err=%0d required 0 0 0",
               hi_viol, idle_wr, err_cnt);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, done, m_write} !== 3'b000) begin
      n_fail++;
      $display("FAIL onepx_after: got busy/done/wr=%b required 000", {busy, done, m_write});
    end
  endtask

  task automatic test_full_screen();
    int d;
    build_exp(8'd0, 8'd239, 9'd0, 9'd319, 16'h07E0);
    do_start(8'd0, 8'd239, 9'd0, 9'd319, 16'h07E0);
    collect(1'b0, 80000, 0, 8'd0, 8'd0, 9'd0, 9'd0, 16'd0);
    d = first_diff();
    n_cmp++;
    if (d >= 0) begin
      n_fail++;
      $display("FAIL fullscr_seq: %s", diff_str(d));
    end
    n_cmp++;
    if (done_cnt !== 1 || done_cyc !== 76814) begin
      n_fail++;
      $display("FAIL fullscr_done: got count %0d cycle %0d required 1 at 76814",
               done_cnt, done_cyc);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL fullscr_after: got busy/done=%b required 00", {busy, done});
    end
  endtask

  task automatic test_backpressure();
    int d;
    build_exp(8'd100, 8'd101, 9'd200, 9'd201, 16'h1234);
    do_start(8'd100, 8'd101, 9'd200, 9'd201, 16'h1234);
    collect(1'b1, 500, 0, 8'd0, 8'd0, 9'd0, 9'd0, 16'd0);
    d = first_diff();
    n_cmp++;
    if (d >= 0) begin
      n_fail++;
      $display("FAIL bp_seq: %s", diff_str(d));
    end
    n_cmp++;
    if (stable_viol !== 0 || wwf_viol !== 0 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL bp_protocol: got unstable=%0d write_full=%0d done=%0d required 0 0 1",
               stable_viol, wwf_viol, done_cnt);
    end
  endtask

  task automatic test_invalid();
    logic [7:0] a0[4], a1[4];
    logic [8:0] b0[4], b1[4];
    int ec, wc;
    a0 = '{8'd10, 8'd0, 8'd0, 8'd3};
    a1 = '{8'd9,  8'd0, 8'd240, 8'd3};
    b0 = '{9'd0,  9'd0, 9'd0, 9'd50};
    b1 = '{9'd0,  9'd320, 9'd0, 9'd49};
    a1[2] = 8'($urandom_range(240, 255));
    b1[1] = 9'($urandom_range(320, 511));
    for (int t = 0; t < 4; t++) begin
      do_start(a0[t], a1[t], b0[t], b1[t], 16'hABCD);
      @(negedge clk);
      n_cmp++;
      if ({err, busy, m_write} !== 3'b100) begin
        n_fail++;
        $display("FAIL invalid%0d_pulse: got err/busy/wr=%b required 100", t,
                 {err, busy, m_write});
      end
      ec = 0;
      wc = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (err) ec++;
        if (m_write || busy) wc++;
      end
      n_cmp++;
      if (ec !== 0 || wc !== 0) begin
        n_fail++;
        $display("FAIL invalid%0d_after: got extra err %0d active %0d required 0 0", t, ec, wc);
      end
    end
  endtask

  task automatic test_reset_mid();
    int d;
    do_start(8'd20, 8'd23, 9'd30, 9'd33, 16'h5A5A);
    repeat (15) @(posedge clk);
    #2;
    n_cmp++;
    if (m_write !== 1'b1 || m_data[16:31] !== 16'h5A5A) begin
      n_fail++;
      $display("FAIL rstmid_pixel3: got wr=%b data=%h required 1 5a5a", m_write, m_data[16:31]);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, err, m_write, m_ctl} !== 5'b0 || m_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_async: got status=%b data=%h required 00000 00000000",
               {busy, done, err, m_write, m_ctl}, m_data);
    end
    @(negedge clk);
    build_exp(8'd7, 8'd7, 9'd9, 9'd9, 16'h00FF);
    rst_n = 1'b1;
    x0 = 8'd7; x1 = 8'd7; y0 = 9'd9; y1 = 9'd9; color = 16'h00FF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    collect(1'b0, 100, 0, 8'd0, 8'd0, 9'd0, 9'd0, 16'd0);
    d = first_diff();
    n_cmp++;
    if (d >= 0 || done_cyc !== 15) begin
      n_fail++;
      $display("FAIL rstmid_refill: done cycle %0d (required 15) %s", done_cyc, diff_str(d));
    end
  endtask

  task automatic test_ignore_start();
    int d;
    build_exp(8'd40, 8'd42, 9'd60, 9'd61, 16'hC0DE);
    do_start(8'd40, 8'd42, 9'd60, 9'd61, 16'hC0DE);
    collect(1'b1, 500, 6, 8'd0, 8'd100, 9'd0, 9'd100, 16'hDEAD);
    d = first_diff();
    n_cmp++;
    if (d >= 0) begin
      n_fail++;
      $display("FAIL ignore_seq: %s", diff_str(d));
    end
    n_cmp++;
    if (err_cnt !== 0 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL ignore_status: got err %0d done %0d required 0 1", err_cnt, done_cnt);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_after: got busy %b required 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int d;
    build_exp(8'd1, 8'd1, 9'd2, 9'd2, 16'h1111);
    do_start(8'd1, 8'd1, 9'd2, 9'd2, 16'h1111);
    // Second request lands in the cycle the first done pulses.
    collect(1'b0, 100, 15, 8'd3, 8'd4, 9'd5, 9'd5, 16'h2222);
    d = first_diff();
    n_cmp++;
    if (d >= 0 || done_cyc !== 15) begin
      n_fail++;
      $display("FAIL b2b_first: done cycle %0d (required 15) %s", done_cyc, diff_str(d));
    end
    build_exp(8'd3, 8'd4, 9'd5, 9'd5, 16'h2222);
    collect(1'b0, 100, 0, 8'd0, 8'd0, 9'd0, 9'd0, 16'd0);
    d = first_diff();
    n_cmp++;
    if (d >= 0 || done_cyc !== 16 || first_wr !== 1) begin
      n_fail++;
      $display("FAIL b2b_second: done cycle %0d first write %0d (required 16, 1) %s",
               done_cyc, first_wr, diff_str(d));
    end
  endtask

  task automatic test_random();
    logic [7:0]  a0, a1;
    logic [8:0]  b0, b1;
    logic [15:0] c;
    bit          rf;
    int          d, n;
    for (int t = 0; t < 8; t++) begin
      a0 = 8'($urandom_range(0, 235));
      a1 = a0 + 8'($urandom_range(0, 4));
      b0 = 9'($urandom_range(0, 315));
      b1 = b0 + 9'($urandom_range(0, 4));
      c  = 16'($urandom);
      rf = 1'($urandom_range(0, 1));
      n  = (int'(a1) - int'(a0) + 1) * (int'(b1) - int'(b0) + 1);
      build_exp(a0, a1, b0, b1, c);
      do_start(a0, a1, b0, b1, c);
      collect(rf, 1000, 0, 8'd0, 8'd0, 9'd0, 9'd0, 16'd0);
      d = first_diff();
      n_cmp++;
      if (d >= 0) begin
        n_fail++;
        $display("FAIL rand%0d_seq: %s", t, diff_str(d));
      end
      n_cmp++;
      if (done_cnt !== 1 || stable_viol !== 0 || wwf_viol !== 0 ||
          (!rf && done_cyc !== 14 + n)) begin
        n_fail++;
        $display("FAIL rand%0d_protocol: got done %0d@%0d unstable %0d wf %0d required 1@%0d 0 0",
                 t, done_cnt, done_cyc, stable_viol, wwf_viol, 14 + n);
      end
    end
  endtask

  initial begin
    start = 1'b0;
    m_full = 1'b0;
    rst_n = 1'b0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0;
    test_reset();
    test_one_pixel();
    test_invalid();
    test_backpressure();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_full_screen();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tft_fill_gen.md
TFT_FILL_GEN -- requirements
Module: tft_fill_gen

Interface
REQ-001 SHALL have parameter: X_MAX, 239, largest legal column index.
REQ-002 SHALL have parameter: Y_MAX, 319, largest legal row index.
REQ-003 SHALL have port: FSL_Clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port: FSL_Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: start  input  1  one-cycle fill request.
REQ-006 SHALL have port: x0, x1  input  8 each  window columns, inclusive.
REQ-007 SHALL have port: y0, y1  input  9 each  window rows, inclusive.
REQ-008 SHALL have port: color  input  16  RGB565 fill value.
REQ-009 SHALL have port: busy  output  1  fill in progress.
REQ-010 SHALL have port: done  output  1  one-cycle pulse after last pixel word accepted.
REQ-011 SHALL have port: err  output  1  one-cycle pulse on rejected request.
REQ-012 SHALL have port: FSL_M_Write  output  1  word valid, FSL master side.
REQ-013 SHALL have port: FSL_M_Data  output  [0:31]  word; payload in [16:31], [0:15] driven 0.
REQ-014 SHALL have port: FSL_M_Control  output  1  1 = LCD register index (RS low), 0 = register/GRAM data.
REQ-015 SHALL have port: FSL_M_Full  input  1  downstream tft_ctrl FIFO full.

Function
REQ-016 SHALL implement states IDLE, SETUP, PIXELS; busy = 1 in SETUP and PIXELS only.
REQ-017 In IDLE, start=1 SHALL latch x0,x1,y0,y1,color and go to SETUP next cycle, provided x0<=x1, y0<=y1, x1<=X_MAX, y1<=Y_MAX.
REQ-018 An invalid request SHALL pulse err for one cycle the following cycle, remain IDLE, emit no words.
REQ-019 start while busy SHALL be ignored (no err, latched values unchanged).
REQ-020 SETUP SHALL emit 13 words in order (Control,payload): (1,0x0050)(0,x0)(1,0x0051)(0,x1)(1,0x0052)(0,y0)(1,0x0053)(0,y1)(1,0x0020)(0,x0)(1,0x0021)(0,y0)(1,0x0022); coordinates zero-extended to 16 bits.
REQ-021 After the 13th word accepted, SHALL enter PIXELS and emit N=(x1-x0+1)*(y1-y0+1) words (0,color); N held in a 17-bit down-counter.
REQ-022 Word transfer: FSL_M_Write = pending word AND NOT FSL_M_Full (same-cycle combinational); word accepted iff FSL_M_Write=1; sequence index/counter advance only on acceptance.
REQ-023 FSL_M_Data/FSL_M_Control SHALL hold stable while FSL_M_Full=1; no word lost or duplicated under any Full pattern.
REQ-024 With FSL_M_Full held 0, SHALL emit one word per cycle back-to-back; first word in first SETUP cycle (start + 1 cycle).
REQ-025 On acceptance of final pixel word: next cycle state IDLE, busy=0, done=1 for exactly one cycle.
REQ-026 A start asserted in the same cycle done pulses SHALL be accepted (state already IDLE).
REQ-027 FSL_M_Write SHALL be 0 in IDLE regardless of other inputs.

Reset
REQ-028 FSL_Rst_n=0 SHALL immediately force: state IDLE, busy=0, done=0, err=0, FSL_M_Write=0, FSL_M_Data=0, FSL_M_Control=0, counters and latches 0.
REQ-029 Reset mid-fill SHALL abort without completing the sequence; after release, block accepts start on first clock edge with FSL_Rst_n=1.

Verification
REQ-030 1x1 fill x0=x1=5,y0=y1=7,color=0xF800, Full=0 -> 14 consecutive writes: 13 setup words per REQ-020, then (0,0xF800); done at cycle 15 after start.
REQ-031 Full screen x 0..239, y 0..319, color 0x07E0 -> 13 setup words + 76800 pixel words, done once, busy low after.
REQ-032 2x2 fill with FSL_M_Full toggling pseudo-randomly -> exact 17-word sequence, data stable during Full, no Write while Full=1.
REQ-033 x0=10,x1=9 and separately y1=320 -> err pulse one cycle, busy=0, zero writes.
REQ-034 Reset asserted during pixel 3 of a 4x4 fill -> all outputs 0 asynchronously; new 1x1 fill afterwards produces exact 14-word sequence.
REQ-035 start pulsed mid-fill with different coords -> ignored; original sequence completes unchanged.
